// File: rtl/led_stimulus_generator.sv
// Timed stimulus source: after a start request, waits delayCycles, then holds
// signalOut high for pulseCycles, reporting its own edges as one-cycle strobes.
module led_stimulus_generator #(
   parameter int DELAY_W = 16,
   parameter int PULSE_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [DELAY_W-1:0] delayCycles,
   input  logic [PULSE_W-1:0] pulseCycles,
   output logic               signalOut,
   output logic               risingEdge,
   output logic               fallingEdge,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = (DELAY_W > PULSE_W) ? DELAY_W : PULSE_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      HIGH  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PULSE_W-1:0] pulse_q, pulse_d;
   logic               sig_q, sig_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = pulse_q;
      sig_d   = sig_q;
      busy_d  = busy_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // abort has priority over a simultaneous start
            if (start && !abort) begin
               cnt_d   = CNT_W'(delayCycles);
               pulse_d = (pulseCycles == '0) ? PULSE_W'(1) : pulseCycles;
               busy_d  = 1'b1;
               state_d = DELAY;
            end
         end
         DELAY: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               sig_d   = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = CNT_W'(pulse_q - PULSE_W'(1));
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (abort) begin
               sig_d   = 1'b0;
               fall_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               sig_d   = 1'b0;
               fall_d  = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            sig_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= '0;
         sig_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         sig_q   <= sig_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign signalOut   = sig_q;
   assign risingEdge  = rise_q;
   assign fallingEdge = fall_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_led_stimulus_generator.sv
// Scoreboard bench for led_stimulus_generator: expected output vectors
// {signalOut,risingEdge,fallingEdge,busy,done} derived from the edge timing.
module tb_led_stimulus_generator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] delayCycles = '0;
   logic [15:0] pulseCycles = '0;
   logic        signalOut, risingEdge, fallingEdge, busy, done;

   int vectors = 0;
   int miscompares = 0;
   logic [4:0] exp_q[$];
   logic [4:0] got, want;

   led_stimulus_generator #(.DELAY_W(16), .PULSE_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .delayCycles(delayCycles), .pulseCycles(pulseCycles),
      .signalOut(signalOut), .risingEdge(risingEdge), .fallingEdge(fallingEdge),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // n = edges since the accepting start edge; ab = abort edge (-1 = none)
   function automatic logic [4:0] exp_wave(int n, int d, int p, int ab);
      int pe;
      pe = (p == 0) ? 1 : p;
      if (n < 0) return 5'b0;
      if (ab >= 0 && n >= ab)
         return (ab >= d + 2 && ab <= d + 1 + pe && n == ab) ? 5'b00100 : 5'b00000;
      return {n >= d + 1 && n <= d + pe, n == d + 1, n == d + 1 + pe,
              n <= d + pe, n == d + 1 + pe};
   endfunction

   task automatic drive(input logic s, input logic a, input int d, input int p);
      start = s;
      abort = a;
      delayCycles = 16'(d);
      pulseCycles = 16'(p);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 13; i++) begin
         reset = (i < 3);
         drive(1'b0, 1'b0, 0, 0);
         exp_q.push_back(5'b0);
         @(posedge clk); #1;
         got = {signalOut, risingEdge, fallingEdge, busy, done};
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL reset cyc %0d: got %b want %b", i, got, want);
         end
      end
      reset = 1'b0;
      $display("reset: checked 13 cycles");
   endtask

   task automatic test_basic();
      int dt[4] = '{3, 7, 1, 4};
      int pt[4] = '{2, 1, 5, 0};
      for (int t = 0; t < 4; t++) begin
         for (int n = 0; n < dt[t] + pt[t] + 5; n++) begin
            drive(n == 0, 1'b0, dt[t], pt[t]);
            exp_q.push_back(exp_wave(n, dt[t], pt[t], -1));
            @(posedge clk); #1;
            got = {signalOut, risingEdge, fallingEdge, busy, done};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("FAIL basic D=%0d P=%0d n=%0d: got %b want %b", dt[t], pt[t], n, got, want);
            end
         end
         $display("basic: D=%0d P=%0d", dt[t], pt[t]);
      end
   endtask

   task automatic test_min();
      for (int p = 0; p < 2; p++) begin
         for (int n = 0; n < 5; n++) begin
            drive(n == 0, 1'b0, 0, p);
            exp_q.push_back(exp_wave(n, 0, p, -1));
            @(posedge clk); #1;
            got = {signalOut, risingEdge, fallingEdge, busy, done};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("FAIL min P=%0d n=%0d: got %b want %b", p, n, got, want);
            end
         end
         $display("min: D=0 P=%0d", p);
      end
   endtask

   task automatic test_back_to_back();
      int dt[2] = '{0, 2};
      int pt[2] = '{0, 1};
      int per, pe;
      logic [4:0] e;
      for (int t = 0; t < 2; t++) begin
         pe = (pt[t] == 0) ? 1 : pt[t];
         per = dt[t] + pe + 2;
         // start held through the third accepting edge
         for (int n = 0; n < 3 * per + 2; n++) begin
            drive(n <= 2 * per, 1'b0, dt[t], pt[t]);
            e = '0;
            for (int j = 0; j < 3; j++) e |= exp_wave(n - j * per, dt[t], pt[t], -1);
            exp_q.push_back(e);
            @(posedge clk); #1;
            got = {signalOut, risingEdge, fallingEdge, busy, done};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("FAIL b2b D=%0d P=%0d n=%0d: got %b want %b", dt[t], pt[t], n, got, want);
            end
         end
         $display("back_to_back: D=%0d P=%0d period %0d", dt[t], pt[t], per);
      end
   endtask

   task automatic test_abort();
      int at[5] = '{8, 3, 6, 16, 2};
      for (int t = 0; t < 5; t++) begin
         for (int n = 0; n < 20; n++) begin
            drive(n == 0, n == at[t], 5, 10);
            exp_q.push_back(exp_wave(n, 5, 10, at[t]));
            @(posedge clk); #1;
            got = {signalOut, risingEdge, fallingEdge, busy, done};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("FAIL abort@%0d n=%0d: got %b want %b", at[t], n, got, want);
            end
         end
         $display("abort: D=5 P=10 abort at edge %0d", at[t]);
      end
   endtask

   task automatic test_ignore();
      for (int n = 0; n < 16; n++) begin
         if (n == 0)                 drive(1'b1, 1'b0, 2, 4);
         else if (n == 2 || n == 5)  drive(1'b1, 1'b0, 9, 1);
         else if (n == 10)           drive(1'b1, 1'b1, 1, 1);
         else if (n == 11)           drive(1'b0, 1'b1, 1, 1);
         else                        drive(1'b0, 1'b0, 0, 0);
         exp_q.push_back(exp_wave(n, 2, 4, -1));
         @(posedge clk); #1;
         got = {signalOut, risingEdge, fallingEdge, busy, done};
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL ignore n=%0d: got %b want %b", n, got, want);
         end
      end
      $display("ignore: restart while busy, start+abort in idle");
   endtask

   task automatic test_reset_mid();
      for (int n = 0; n < 33; n++) begin
         reset = (n == 12);
         drive(n == 0 || n == 14, 1'b0, 10, 5);
         exp_q.push_back((n < 12) ? exp_wave(n, 10, 5, -1) : exp_wave(n - 14, 10, 5, -1));
         @(posedge clk); #1;
         got = {signalOut, risingEdge, fallingEdge, busy, done};
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL reset_mid n=%0d: got %b want %b", n, got, want);
         end
      end
      reset = 1'b0;
      $display("reset_mid: reset at edge 12, restart at 14");
   endtask

   task automatic test_max_delay();
      for (int n = 0; n < 65535 + 7; n++) begin
         drive(n == 0, 1'b0, 65535, 3);
         exp_q.push_back(exp_wave(n, 65535, 3, -1));
         @(posedge clk); #1;
         got = {signalOut, risingEdge, fallingEdge, busy, done};
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            if (miscompares < 20)
               $display("FAIL max_delay n=%0d: got %b want %b", n, got, want);
         end
      end
      $display("max_delay: D=65535 P=3");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_min();
      test_back_to_back();
      test_abort();
      test_ignore();
      test_reset_mid();
      test_max_delay();
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
